// File: rtl/riscv_pkg.sv
// RV32I opcode, instruction-kind and funct3 constants shared by the encoder and the ctrl/alu decode path.
// Constants only; no logic, latency or backpressure of its own.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_IMM    = 3'd1,
    KIND_LOAD   = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JAL    = 3'd5
  } instr_kind_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: builds the RV32I word for one bundle and flags out-of-range immediates.
// Zero latency; no handshake, the caller decides when the result is used.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [2:0]  f3_i,
  input  logic        f7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  logic fits12;
  logic fits13;
  logic fits21;
  logic is_shift;

  // fitsN: imm is representable as an N-bit signed value
  assign fits12   = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign fits13   = (&imm_i[31:12]) || !(|imm_i[31:12]);
  assign fits21   = (&imm_i[31:20]) || !(|imm_i[31:20]);
  assign is_shift = (f3_i == F3_SLL) || (f3_i == F3_SRL_SRA);

  always_comb begin
    instr_o = '0;
    legal_o = 1'b0;
    case (kind_i)
      KIND_R: begin
        instr_o = {1'b0, f7b5_i, 5'b00000, rs2_i, rs1_i, f3_i, rd_i, OP_R};
        legal_o = 1'b1;
      end
      KIND_IMM: begin
        if (is_shift) begin
          instr_o = {1'b0, f7b5_i, 5'b00000, imm_i[4:0], rs1_i, f3_i, rd_i, OP_IMM};
          legal_o = !(|imm_i[31:5]);
        end else begin
          instr_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OP_IMM};
          legal_o = fits12;
        end
      end
      KIND_LOAD: begin
        instr_o = {imm_i[11:0], rs1_i, f3_i, rd_i, OP_LOAD};
        legal_o = fits12;
      end
      KIND_STORE: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], OP_STORE};
        legal_o = fits12;
      end
      KIND_BRANCH: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1], imm_i[11], OP_BRANCH};
        legal_o = fits13 && !imm_i[0];
      end
      KIND_JAL: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        legal_o = fits21 && !imm_i[0];
      end
      default: begin
        instr_o = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field bundles into RV32I words with a byte address; legal words appear 1 cycle after acceptance.
// Single output register: in_ready = !out_valid || out_ready, output held stable while stalled.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_q,       err_d;

  logic [31:0]       enc_instr;
  logic              enc_legal;
  logic              accept;
  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_base_lsbs;

  imm_pack u_imm_pack (
    .kind_i  (in_kind),
    .f3_i    (in_funct3),
    .f7b5_i  (in_funct7b5),
    .rd_i    (in_rd),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .imm_i   (in_imm),
    .instr_o (enc_instr),
    .legal_o (enc_legal)
  );

  assign in_ready         = !out_valid_q || out_ready;
  assign accept           = in_valid && in_ready;
  assign base_aligned     = {addr_base[ADDR_W-1:2], 2'b00};
  assign unused_base_lsbs = ^addr_base[1:0];
  // A load in the same cycle as an acceptance addresses that very word
  assign word_addr        = addr_load ? base_aligned : next_addr_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    err_d       = accept && !enc_legal;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (addr_load) begin
      next_addr_d = base_aligned;
    end
    if (accept && enc_legal) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_addr_d  = word_addr;
      next_addr_d = word_addr + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      next_addr_q <= RESET_ADDR;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;

endmodule
